sc_stoch_to_bin: RTL

// - Stochastic-to-binary converter. Sits directly downstream of the SC activation FSMs (ReLU/tanh).
// - Counts the 1s in the activation output bitstream over a fixed window of L = 2**WIN_LOG2 accepted bits.
// - Returns the count as a binary word to the next layer or accumulator over a valid/ready handshake.

---
 rtl/sc_stoch_to_bin.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sc_stoch_to_bin.sv
// rtl/sc_stoch_to_bin.sv - stochastic bitstream to binary count converter
//
// Purpose:
//   Counts the 1s in an SC activation bitstream over a window of
//   L = 2**WIN_LOG2 accepted bits. The count is returned over a valid/ready
//   handshake. The result is held until downstream accepts it.
//
// Parameters:
//   WIN_LOG2    log2 of the window length L
//   CONTINUOUS  0: go back to IDLE after each result
//               1: re-arm the accumulator directly after the handshake
//
// Ports:
//   clk        in   clock, all state updates on posedge
//   reset      in   asynchronous, active-high
//   start      in   begin a window (sampled only in IDLE)
//   x          in   stochastic bit
//   x_valid    in   x carries a valid bit this cycle
//   x_ready    out  converter accepts x (high only while accumulating)
//   out_data   out  result word, WIN_LOG2+2 bits
//   out_valid  out  out_data valid, held until accepted
//   out_ready  in   downstream accepts out_data
//   busy       out  accumulating or holding a result
//
// Build option:
//   BIPOLAR_OUT_EN  defined:   out_data = 2*ones - L (2's complement)
//                   undefined: out_data = zero-extended ones count
module sc_stoch_to_bin #(
  parameter int WIN_LOG2   = 4,
  parameter int CONTINUOUS = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                x,
  input  logic                x_valid,
  output logic                x_ready,
  output logic [WIN_LOG2+1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int L  = 1 << WIN_LOG2;
  localparam int CW = WIN_LOG2 + 1;
  localparam int OW = WIN_LOG2 + 2;
  localparam logic [WIN_LOG2-1:0] IDX_LAST = WIN_LOG2'(L - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       ones_cnt_q, ones_cnt_d;
  logic [WIN_LOG2-1:0] bit_idx_q, bit_idx_d;
  logic [OW-1:0]       out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                x_ready_q, x_ready_d;
  logic                busy_q, busy_d;

  logic                beat;
  logic [CW-1:0]       ones_sum;
  logic [OW-1:0]       mapped;

  // A beat uses the registered x_ready, which is high exactly in ACCUM.
  assign beat     = x_valid & x_ready_q;
  // The count includes the current bit, so the final beat's x reaches the result.
  assign ones_sum = ones_cnt_q + CW'(x);

`ifdef BIPOLAR_OUT_EN
  // 2*ones - L. The shifted count fills all OW bits, so the subtraction wraps
  // into a correct 2's complement value over -L..+L.
  assign mapped = {ones_sum, 1'b0} - OW'(L);
`else
  assign mapped = {1'b0, ones_sum};
`endif

  always_comb begin
    state_d     = state_q;
    ones_cnt_d  = ones_cnt_q;
    bit_idx_d   = bit_idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ACCUM;
          ones_cnt_d = '0;
          bit_idx_d  = '0;
        end
      end
      S_ACCUM: begin
        if (beat) begin
          ones_cnt_d = ones_sum;
          bit_idx_d  = bit_idx_q + 1'b1;
          if (bit_idx_q == IDX_LAST) begin
            out_data_d  = mapped;
            out_valid_d = 1'b1;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (CONTINUOUS != 0) begin
            state_d    = S_ACCUM;
            ones_cnt_d = '0;
            bit_idx_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Registered status outputs follow the next state so they line up with it.
    x_ready_d = (state_d == S_ACCUM);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ones_cnt_q  <= '0;
      bit_idx_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      x_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ones_cnt_q  <= ones_cnt_d;
      bit_idx_q   <= bit_idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      x_ready_q   <= x_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign x_ready   = x_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
